// File: rtl/hack_pkg.sv
// Shared definitions for the Hack-style controller: FSM state encoding and
// instruction field bit positions.
package hack_pkg;

   localparam int INSTR_WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      EXEC  = 2'd2,
      HALT  = 2'd3
   } state_t;

   // Instruction field bit positions
   localparam int BIT_CI     = 15;
   localparam int BIT_AM     = 12;
   localparam int BIT_ZX     = 11;
   localparam int BIT_NX     = 10;
   localparam int BIT_ZY     = 9;
   localparam int BIT_NY     = 8;
   localparam int BIT_F      = 7;
   localparam int BIT_NO     = 6;
   localparam int BIT_DEST_A = 5;
   localparam int BIT_DEST_D = 4;
   localparam int BIT_DEST_M = 3;
   localparam int BIT_J_LT   = 2;
   localparam int BIT_J_EQ   = 1;
   localparam int BIT_J_GT   = 0;

endpackage

// File: rtl/hack_alu.sv
// Combinational Hack ALU: operand zero/invert stages, add-or-and function,
// optional output inversion, plus zero and negative flags.
module hack_alu #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             zx,
   input  logic             nx,
   input  logic             zy,
   input  logic             ny,
   input  logic             f,
   input  logic             no,
   output logic [WIDTH-1:0] result,
   output logic             zr,
   output logic             ng
);

   logic [WIDTH-1:0] x_op;
   logic [WIDTH-1:0] y_op;
   logic [WIDTH-1:0] fn_out;

   always_comb begin
      x_op = zx ? '0 : x;
      if (nx) begin
         x_op = ~x_op;
      end
      y_op = zy ? '0 : y;
      if (ny) begin
         y_op = ~y_op;
      end
      fn_out = f ? (x_op + y_op) : (x_op & y_op);
      result = no ? ~fn_out : fn_out;
      zr     = (result == '0);
      ng     = result[WIDTH-1];
   end

endmodule

// File: rtl/hack_ctrl.sv
// Fetch/decode/execute controller for a Hack-style machine, two cycles per
// instruction. Optional retired-instruction counter: define HACK_CTRL_RETIRE_CNT_EN.
module hack_ctrl
   import hack_pkg::*;
#(
   parameter int BUS_WIDTH = 8
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_start,
   input  logic [INSTR_WIDTH-1:0] i_instr,
   input  logic [BUS_WIDTH-1:0]   i_A,
   input  logic [BUS_WIDTH-1:0]   i_D,
   input  logic [BUS_WIDTH-1:0]   i_P,
   output logic [BUS_WIDTH-1:0]   o_pc,
   output logic [BUS_WIDTH-1:0]   o_X,
   output logic                   o_a,
   output logic                   o_d,
   output logic                   o_p,
   output logic                   o_busy,
`ifdef HACK_CTRL_RETIRE_CNT_EN
   output logic                   o_halted,
   output logic [31:0]            o_retired
`else
   output logic                   o_halted
`endif
);

   state_t               state_reg;
   state_t               state_next;
   logic [BUS_WIDTH-1:0] pc_reg;
   logic [BUS_WIDTH-1:0] pc_next;

   logic                 exec_active;
   logic                 is_c;
   logic [BUS_WIDTH-1:0] a_imm;
   logic [BUS_WIDTH-1:0] alu_y;
   logic [BUS_WIDTH-1:0] alu_result;
   logic                 alu_zr;
   logic                 alu_ng;
   logic                 jump_taken;
   logic                 halt_hit;
   logic                 unused_instr_bits;

   // Bits 14:13 of a C-instruction carry no meaning.
   assign unused_instr_bits = &{1'b0, i_instr[14:13]};

   assign exec_active = (state_reg == EXEC) && !i_rst;
   assign is_c        = i_instr[BIT_CI];

   generate
      if (BUS_WIDTH > 15) begin : g_imm_wide
         assign a_imm = {{(BUS_WIDTH-15){1'b0}}, i_instr[14:0]};
      end else begin : g_imm_narrow
         assign a_imm = i_instr[BUS_WIDTH-1:0];
      end
   endgenerate

   assign alu_y = i_instr[BIT_AM] ? i_P : i_A;

   hack_alu #(
      .WIDTH (BUS_WIDTH)
   ) u_alu (
      .x      (i_D),
      .y      (alu_y),
      .zx     (i_instr[BIT_ZX]),
      .nx     (i_instr[BIT_NX]),
      .zy     (i_instr[BIT_ZY]),
      .ny     (i_instr[BIT_NY]),
      .f      (i_instr[BIT_F]),
      .no     (i_instr[BIT_NO]),
      .result (alu_result),
      .zr     (alu_zr),
      .ng     (alu_ng)
   );

   assign jump_taken = is_c &
                       ((i_instr[BIT_J_LT] & alu_ng) |
                        (i_instr[BIT_J_EQ] & alu_zr) |
                        (i_instr[BIT_J_GT] & ~alu_ng & ~alu_zr));

   // A jump onto itself is the conventional end-of-program idiom.
   assign halt_hit = jump_taken && (i_A == pc_reg);

   always_comb begin
      o_X = '0;
      o_a = 1'b0;
      o_d = 1'b0;
      o_p = 1'b0;
      if (exec_active) begin
         if (is_c) begin
            o_X = alu_result;
            o_a = i_instr[BIT_DEST_A];
            o_d = i_instr[BIT_DEST_D];
            o_p = i_instr[BIT_DEST_M];
         end else begin
            o_X = a_imm;
            o_a = 1'b1;
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      pc_next    = pc_reg;
      case (state_reg)
         IDLE, HALT: begin
            if (i_start) begin
               state_next = FETCH;
               pc_next    = '0;
            end
         end
         FETCH: begin
            state_next = EXEC;
         end
         EXEC: begin
            pc_next    = jump_taken ? i_A : (pc_reg + BUS_WIDTH'(1));
            state_next = halt_hit ? HALT : FETCH;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_reg <= IDLE;
         pc_reg    <= '0;
      end else begin
         state_reg <= state_next;
         pc_reg    <= pc_next;
      end
   end

   assign o_pc     = pc_reg;
   assign o_busy   = (state_reg == FETCH) || (state_reg == EXEC);
   assign o_halted = (state_reg == HALT);

`ifdef HACK_CTRL_RETIRE_CNT_EN
   logic [31:0] retired_reg;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         retired_reg <= '0;
      end else if (((state_reg == IDLE) || (state_reg == HALT)) && i_start) begin
         retired_reg <= '0;
      end else if (state_reg == EXEC) begin
         retired_reg <= retired_reg + 32'd1;
      end
   end

   assign o_retired = retired_reg;
`endif

endmodule

// File: tb/tb_hack_ctrl.sv
// Self-checking bench for hack_ctrl: directed scenarios followed by random
// instructions checked against an arithmetic reference model.
module tb_hack_ctrl;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_start;
   logic [15:0] i_instr;
   logic [7:0]  i_A;
   logic [7:0]  i_D;
   logic [7:0]  i_P;
   logic [7:0]  o_pc;
   logic [7:0]  o_X;
   logic        o_a;
   logic        o_d;
   logic        o_p;
   logic        o_busy;
   logic        o_halted;
`ifdef HACK_CTRL_RETIRE_CNT_EN
   logic [31:0] o_retired;
`endif

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  m_pc;
   int unsigned m_ret;

   hack_ctrl #(
      .BUS_WIDTH (8)
   ) dut (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_start  (i_start),
      .i_instr  (i_instr),
      .i_A      (i_A),
      .i_D      (i_D),
      .i_P      (i_P),
      .o_pc     (o_pc),
      .o_X      (o_X),
      .o_a      (o_a),
      .o_d      (o_d),
      .o_p      (o_p),
      .o_busy   (o_busy),
`ifdef HACK_CTRL_RETIRE_CNT_EN
      .o_halted (o_halted),
      .o_retired(o_retired)
`else
      .o_halted (o_halted)
`endif
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: Hack semantics in plain arithmetic, jump decided by signed compare.
   task automatic model(input logic [15:0] ins, input logic [7:0] a, input logic [7:0] d,
                        input logic [7:0] p, input logic [7:0] pc,
                        output logic ea, output logic ed, output logic ep,
                        output logic [7:0] ex, output logic [7:0] npc, output logic halt);
      logic [7:0] x;
      logic [7:0] y;
      logic [7:0] r;
      byte        sr;
      bit         take;
      if (ins[15] == 1'b0) begin
         ea = 1'b1; ed = 1'b0; ep = 1'b0;
         ex = ins[7:0];
         npc = pc + 8'd1;
         halt = 1'b0;
      end else begin
         x = ins[11] ? 8'd0 : d;
         if (ins[10]) x = ~x;
         y = ins[12] ? p : a;
         if (ins[9]) y = 8'd0;
         if (ins[8]) y = ~y;
         r = ins[7] ? 8'((int'(x) + int'(y)) % 256) : (x & y);
         if (ins[6]) r = ~r;
         sr = signed'(r);
         take = (ins[2] && sr < 0) || (ins[1] && sr == 0) || (ins[0] && sr > 0);
         ea = ins[5]; ed = ins[4]; ep = ins[3];
         ex = r;
         npc = take ? a : pc + 8'd1;
         halt = take && (a == pc);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_a"}, o_a, 1'b0);
      check({tag, "_d"}, o_d, 1'b0);
      check({tag, "_p"}, o_p, 1'b0);
      check({tag, "_X"}, o_X, 8'd0);
   endtask

   // Called at a negedge in IDLE or HALT; leaves the bench at a negedge in FETCH.
   task automatic do_start();
      i_start = 1'b1;
      @(posedge i_clk);
      #1 i_start = 1'b0;
      m_pc = 8'd0;
      m_ret = 0;
      @(negedge i_clk);
      check("start_busy", o_busy, 1'b1);
      check("start_halted", o_halted, 1'b0);
      check("start_pc", o_pc, 8'd0);
      check_idle_outputs("fetch");
   endtask

   // Called at a negedge in FETCH; runs one full instruction.
   task automatic exec_one(input logic [15:0] ins, input logic [7:0] a, input logic [7:0] d,
                           input logic [7:0] p, input bit noise_start, output logic halt);
      logic       ea, ed, ep;
      logic [7:0] ex, npc;
      model(ins, a, d, p, m_pc, ea, ed, ep, ex, npc, halt);
      i_instr = ins; i_A = a; i_D = d; i_P = p;
      i_start = noise_start;
      @(posedge i_clk);
      @(negedge i_clk);
      check("exec_a", o_a, ea);
      check("exec_d", o_d, ed);
      check("exec_p", o_p, ep);
      check("exec_X", o_X, ex);
      check("exec_busy", o_busy, 1'b1);
      @(posedge i_clk);
      #1 i_start = 1'b0;
      @(negedge i_clk);
      m_ret++;
      check("next_pc", o_pc, npc);
      check("next_halted", o_halted, halt);
      check("next_busy", o_busy, !halt);
      $display("exec pc=%02h instr=%04h A=%02h D=%02h P=%02h -> X=%02h a%0d d%0d p%0d next_pc=%02h halt=%0d",
               m_pc, ins, a, d, p, o_X, ea, ed, ep, o_pc, halt);
      m_pc = npc;
   endtask

   initial begin
      logic h;
      logic [15:0] ins;
      logic [7:0]  a;
      i_rst = 1'b1; i_start = 1'b0; i_instr = 16'h0000;
      i_A = 8'd0; i_D = 8'd0; i_P = 8'd0;
      m_pc = 8'd0; m_ret = 0;
      repeat (2) @(posedge i_clk);
      #1 i_rst = 1'b0;
      @(negedge i_clk);
      check("rst_pc", o_pc, 8'd0);
      check("rst_busy", o_busy, 1'b0);
      check("rst_halted", o_halted, 1'b0);
      check_idle_outputs("rst");
`ifdef HACK_CTRL_RETIRE_CNT_EN
      check("rst_retired", o_retired, 32'd0);
`endif

      // Directed sequence
      do_start();
      exec_one(16'h0005, 8'h00, 8'h00, 8'h00, 1'b0, h);
      exec_one(16'hEC10, 8'h05, 8'h00, 8'h00, 1'b0, h);
      exec_one(16'hE7C8, 8'h00, 8'h05, 8'h00, 1'b0, h);
      exec_one(16'hE301, 8'h20, 8'h03, 8'h00, 1'b1, h);
      exec_one(16'hE301, 8'h20, 8'h00, 8'h00, 1'b0, h);
      exec_one(16'hE301, 8'h20, 8'h80, 8'h00, 1'b0, h);
      exec_one(16'hEA87, 8'hFF, 8'h00, 8'h00, 1'b0, h);
      exec_one(16'h0001, 8'h00, 8'h00, 8'h00, 1'b0, h);
      check("wrap_pc", o_pc, 8'h00);
      exec_one(16'hEA87, 8'h07, 8'h00, 8'h00, 1'b0, h);
      exec_one(16'hEA87, 8'h07, 8'h00, 8'h00, 1'b0, h);
      check("halt_entered", h, 1'b1);
      @(negedge i_clk);
      check("halt_hold_pc", o_pc, 8'h07);
      check("halt_hold_halted", o_halted, 1'b1);
      check_idle_outputs("halt");
`ifdef HACK_CTRL_RETIRE_CNT_EN
      check("halt_retired", o_retired, m_ret);
`endif
      do_start();

      // Reset during EXEC must suppress the write
      i_instr = 16'hE7C8; i_D = 8'h05;
      @(posedge i_clk);
      @(negedge i_clk);
      check("pre_rst_p", o_p, 1'b1);
      i_rst = 1'b1;
      #1;
      check("rst_exec_p", o_p, 1'b0);
      check("rst_exec_X", o_X, 8'd0);
      @(posedge i_clk);
      #1 i_rst = 1'b0;
      @(negedge i_clk);
      m_pc = 8'd0; m_ret = 0;
      check("rst2_pc", o_pc, 8'd0);
      check("rst2_busy", o_busy, 1'b0);
      check("rst2_halted", o_halted, 1'b0);
      check_idle_outputs("rst2");

      // Random instructions against the model
      do_start();
      for (int n = 0; n < 120; n++) begin
         case ($urandom_range(0, 3))
            0:       ins = {1'b0, 15'($urandom)};
            1:       ins = {1'b1, 15'($urandom)};
            default: ins = {3'b111, 13'($urandom)};
         endcase
         a = ($urandom_range(0, 4) == 0) ? m_pc : 8'($urandom);
         exec_one(ins, a, 8'($urandom), 8'($urandom), 1'($urandom), h);
         if (h) begin
`ifdef HACK_CTRL_RETIRE_CNT_EN
            check("rand_retired", o_retired, m_ret);
`endif
            do_start();
         end
      end
`ifdef HACK_CTRL_RETIRE_CNT_EN
      check("final_retired", o_retired, m_ret);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hack_ctrl.md
Name: hack_ctrl

Overview:
Fetch/decode/execute controller that sits directly upstream of the A/D/RAM storage stage. Each cycle it reads the stage's A, D and P (memory-at-A) outputs and supplies the data bus X plus the load strobes a/d/p. Instruction format is Hack-style (16-bit A- and C-instructions) from an external synchronous-read instruction ROM. It holds the program counter, a small control FSM, the ALU and the jump logic.

Parameters:
- BUS_WIDTH, 8, datapath width; also the width of the PC and ROM address.

Ports:
- i_clk  in  1  system clock, rising edge
- i_rst  in  1  synchronous, active-high reset
- i_start  in  1  single-cycle pulse: begin execution from pc 0
- i_instr  in  16  ROM data; valid the cycle after o_pc is presented
- i_A  in  BUS_WIDTH  current A register value from the storage stage
- i_D  in  BUS_WIDTH  current D register value from the storage stage
- i_P  in  BUS_WIDTH  RAM[A] read data from the storage stage
- o_pc  out  BUS_WIDTH  ROM address (registered)
- o_X  out  BUS_WIDTH  write data bus to the storage stage
- o_a, o_d, o_p  out  1 each  load strobes for A, D and RAM[A]
- o_busy  out  1  high in FETCH/EXEC
- o_halted  out  1  high in HALT

Behaviour:
- One clock domain (i_clk). Reset is synchronous and active-high on i_rst.
- Reset values: state=IDLE, o_pc=0, o_busy=0, o_halted=0, o_a=o_d=o_p=0, o_X=0.
- States: IDLE, FETCH, EXEC, HALT.
  - IDLE: i_start moves to FETCH with pc=0.
  - FETCH: o_pc is stable; the ROM read is in flight; moves to EXEC.
  - EXEC: i_instr is valid; strobes are asserted for this one cycle; pc updates; next state is FETCH, or HALT.
  - HALT: i_start restarts at pc=0 and moves to FETCH.
- Timing: 2 cycles per instruction. Every write and the pc update commit on the rising edge that ends EXEC.
- Strobes and o_X: combinational from state and i_instr. They are forced to 0 outside EXEC and whenever i_rst=1, so a reset during EXEC writes nothing.
- A-instruction (bit15=0): o_a=1, o_X=i_instr[BUS_WIDTH-1:0] (zero-extended if BUS_WIDTH>15). No jump.
- C-instruction (bits15:13=111):
  - Field layout: bit12=am; bits11:6 = zx,nx,zy,ny,f,no; bits5:3 = dest A,D,M; bits2:0 = j_lt,j_eq,j_gt.
  - Other bit15=1 patterns execute as C-instructions; bits14:13 are ignored.
  - ALU: x=i_D, y = am ? i_P : i_A.
  - Operand stage: zx zeroes x, then nx inverts x; zy/ny do the same for y.
  - Function: f=1 gives x+y modulo 2^BUS_WIDTH; f=0 gives x&y. no inverts the result.
  - o_X = ALU result. o_a=dest[2], o_d=dest[1], o_p=dest[0]. All three may be asserted together.
  - The RAM write uses the pre-update A, because the storage stage samples its address on the same edge.
- Jump condition: result is signed (MSB). zr = (result==0), ng = MSB. Take the jump if (j_lt & ng) | (j_eq & zr) | (j_gt & ~ng & ~zr).
  - Taken: pc = i_A, using the pre-update A value even when dest includes A.
  - Otherwise: pc = pc+1, wrapping 2^BUS_WIDTH-1 to 0.
- Halt detection: an EXEC with a taken jump where i_A == o_pc enters HALT; pc is held.
  - The instruction's writes still commit.
  - Next cycle: o_halted=1, o_busy=0.
- i_start is ignored in FETCH and EXEC.
- i_rst has priority over i_start.

Optional Feature:
- Macro HACK_CTRL_RETIRE_CNT_EN.
- When defined: extra output o_retired [31:0] counts EXEC cycles completed without reset.
  - Reset value 0; cleared on i_start from IDLE/HALT.
  - Wraps at 2^32.
  - Increments on the halting instruction too.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package hack_pkg holds:
  - state encoding (IDLE=0, FETCH=1, EXEC=2, HALT=3)
  - instruction field bit positions (AM, ZX..NO, DEST_A/D/M, J_LT/EQ/GT)
  - INSTR_WIDTH=16
- One sub-module: hack_alu (purely combinational; x, y and the six control bits in; result, zr, ng out), instantiated once.

Test Plan:
- Reset, then i_start; instr 16'h0005 -> FETCH with o_pc=0, then EXEC with o_a=1, o_X=5, o_d=o_p=0; o_pc=1 two cycles after start.
- instr 16'hEC10 (D=A), i_A=5 -> EXEC: o_d=1, o_X=5, o_a=o_p=0.
- instr 16'hE7C8 (M=D+1), i_D=5 -> o_p=1, o_X=6.
- instr 16'hE301 (D;JGT), i_A=8'h20:
  - i_D=3 -> next o_pc=8'h20
  - i_D=0 -> o_pc+1
  - i_D=8'h80 -> o_pc+1
- pc=8'hFF, instr 16'h0001 -> o_pc wraps to 0.
- Halt and reset:
  - pc=7, i_A=7, instr 16'hEA87 (0;JMP) -> o_halted=1, o_busy=0, o_pc stays 7; i_start -> o_pc=0, FETCH.
  - i_rst asserted during EXEC of 16'hE7C8 -> o_p=0 in that cycle; all outputs at reset values next cycle.
